// File: rtl/alu_rtl.sv
// ---------------------------------------------------------------------------
// alu_rtl -- 8-bit registered ALU (datapath leaf).
//
// A purely combinational decode selects one of three operation groups
// (arithmetic, bitwise logic, single-bit shift/rotate) and the chosen
// value is captured in one 8-bit output register on each rising clock
// edge. There is no handshake: a new operation is accepted every cycle
// and its result is visible one cycle later.
//
// Ports:
//   clk                 in   1  system clock, rising-edge active
//   rst                 in   1  synchronous active-high reset (final_result <= 0)
//   a                   in   8  operand A
//   b                   in   8  operand B
//   cin                 in   1  carry-in, arithmetic group only
//   select              in   3  operation group select
//   select_Calculation  in   2  arithmetic sub-op (select = 000)
//   select_Logic        in   2  logic sub-op (select = 001)
//   final_result        out  8  registered result
//
// The result port is named final_result because "final" is a reserved
// word in SystemVerilog.
// ---------------------------------------------------------------------------
module alu_rtl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [2:0] select,
    input  logic [1:0] select_Calculation,
    input  logic [1:0] select_Logic,
    output logic [7:0] final_result
);

    typedef enum logic [2:0] {
        GRP_ARITH = 3'b000,
        GRP_LOGIC = 3'b001,
        GRP_SHL   = 3'b010,
        GRP_SHR   = 3'b011,
        GRP_ASR   = 3'b100,
        GRP_ROL   = 3'b101,
        GRP_RSV6  = 3'b110,
        GRP_RSV7  = 3'b111
    } op_group_t;

    typedef enum logic [1:0] {
        CALC_ADD = 2'b00,
        CALC_SUB = 2'b01,
        CALC_INC = 2'b10,
        CALC_DEC = 2'b11
    } calc_op_t;

    typedef enum logic [1:0] {
        LOG_AND = 2'b00,
        LOG_OR  = 2'b01,
        LOG_XOR = 2'b10,
        LOG_NOT = 2'b11
    } logic_op_t;

    op_group_t  grp;
    calc_op_t   calc_op;
    logic_op_t  logic_op;

    logic [7:0] arith_operand;
    logic [8:0] arith_sum;
    logic [7:0] arith_res;
    logic [7:0] logic_res;
    logic [7:0] shift_res;
    logic [7:0] next_result;

    assign grp      = op_group_t'(select);
    assign calc_op  = calc_op_t'(select_Calculation);
    assign logic_op = logic_op_t'(select_Logic);

    // All four arithmetic sub-ops share one 9-bit adder: only the second
    // operand changes (b, ~b, 0, all-ones); cin always enters as carry-in.
    always_comb begin
        arith_operand = '0;
        case (calc_op)
            CALC_ADD: arith_operand = b;
            CALC_SUB: arith_operand = ~b;
            CALC_INC: arith_operand = '0;
            CALC_DEC: arith_operand = '1;
            default:  arith_operand = '0;
        endcase
    end

    // Carry-out (bit 8) is intentionally dropped; results wrap modulo 256.
    assign arith_sum = {1'b0, a} + {1'b0, arith_operand} + {8'b0, cin};
    assign arith_res = arith_sum[7:0];

    always_comb begin
        logic_res = '0;
        case (logic_op)
            LOG_AND: logic_res = a & b;
            LOG_OR:  logic_res = a | b;
            LOG_XOR: logic_res = a ^ b;
            LOG_NOT: logic_res = ~a;
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (grp)
            GRP_SHL: shift_res = {a[6:0], 1'b0};
            GRP_SHR: shift_res = {1'b0, a[7:1]};
            GRP_ASR: shift_res = {a[7], a[7:1]};
            GRP_ROL: shift_res = {a[6:0], a[7]};
            default: shift_res = '0;
        endcase
    end

    always_comb begin
        next_result = '0;
        case (grp)
            GRP_ARITH: next_result = arith_res;
            GRP_LOGIC: next_result = logic_res;
            GRP_SHL,
            GRP_SHR,
            GRP_ASR,
            GRP_ROL:   next_result = shift_res;
            GRP_RSV6,
            GRP_RSV7:  next_result = '0;
            default:   next_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            final_result <= '0;
        end else begin
            final_result <= next_result;
        end
    end

endmodule

// File: tb/tb_alu_rtl.sv
// ---------------------------------------------------------------------------
// tb_alu_rtl -- self-checking bench for alu_rtl.
// Directed vectors with hand-computed results, then random operations
// checked against an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_rtl;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [2:0] select;
    logic [1:0] select_Calculation;
    logic [1:0] select_Logic;
    logic [7:0] final_result;

    int unsigned n_compared;
    int unsigned n_failed;

    alu_rtl dut (
        .clk                (clk),
        .rst                (rst),
        .a                  (a),
        .b                  (b),
        .cin                (cin),
        .select             (select),
        .select_Calculation (select_Calculation),
        .select_Logic       (select_Logic),
        .final_result       (final_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic logic [7:0] model(input int ia, input int ib, input int ic,
                                         input int sel, input int calc, input int lg);
        int r;
        r = 0;
        case (sel)
            0: case (calc)
                   0: r = (ia + ib + ic) % 256;
                   1: r = (ia + (255 - ib) + ic) % 256;
                   2: r = (ia + ic) % 256;
                   default: r = (ia + 255 + ic) % 256;
               endcase
            1: case (lg)
                   0: r = ia & ib;
                   1: r = ia | ib;
                   2: r = ia ^ ib;
                   default: r = 255 - ia;
               endcase
            2: r = (ia * 2) % 256;
            3: r = ia / 2;
            4: r = ia / 2 + ((ia >= 128) ? 128 : 0);
            5: r = (ia * 2) % 256 + ia / 128;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         input logic [2:0] vs, input logic [1:0] vcalc,
                         input logic [1:0] vlg, input logic vrst);
        a = va; b = vb; cin = vc; select = vs;
        select_Calculation = vcalc; select_Logic = vlg; rst = vrst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] expected);
        n_compared++;
        assert (final_result === expected)
        else begin
            n_failed++;
            $error("FAIL %s: observed %h expected %h", tag, final_result, expected);
        end
    endtask

    task automatic op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input logic vc, input logic [2:0] vs, input logic [1:0] vcalc,
                      input logic [1:0] vlg, input logic [7:0] expected);
        drive(va, vb, vc, vs, vcalc, vlg, 1'b0);
        tick();
        check(tag, expected);
    endtask

    initial begin
        logic [7:0] ra, rb, exp_v;
        logic       rc, rr;
        logic [2:0] rs;
        logic [1:0] rcalc, rlg;

        n_compared = 0;
        n_failed   = 0;

        // Reset held for two edges, with a live add on the inputs.
        drive(8'h55, 8'hB5, 1'b0, 3'b000, 2'b00, 2'b00, 1'b1);
        tick();
        check("reset_edge1", 8'h00);
        tick();
        check("reset_edge2", 8'h00);
        rst = 1'b0;
        #3;
        check("reset_release_hold", 8'h00);

        // Arithmetic
        op("add_carry_drop", 8'h55, 8'hB5, 1'b0, 3'b000, 2'b00, 2'b00, 8'h0A);
        op("sub",            8'hDB, 8'hAA, 1'b1, 3'b000, 2'b01, 2'b00, 8'h31);
        op("inc",            8'hDB, 8'hAA, 1'b1, 3'b000, 2'b10, 2'b00, 8'hDC);
        op("dec",            8'hDB, 8'hAA, 1'b0, 3'b000, 2'b11, 2'b00, 8'hDA);

        // Output holds between edges while inputs change.
        drive(8'h00, 8'h00, 1'b0, 3'b111, 2'b00, 2'b00, 1'b0);
        #3;
        check("hold_between_edges", 8'hDA);

        // Logic (sub-select for arithmetic set to something non-zero to show it is ignored)
        op("and", 8'h2A, 8'hE3, 1'b1, 3'b001, 2'b11, 2'b00, 8'h22);
        op("or",  8'h2A, 8'hE3, 1'b1, 3'b001, 2'b10, 2'b01, 8'hEB);
        op("xor", 8'h2A, 8'hE3, 1'b0, 3'b001, 2'b01, 2'b10, 8'hC9);
        op("not", 8'h2A, 8'hE3, 1'b0, 3'b001, 2'b00, 2'b11, 8'hD5);

        // Shifts / rotate
        op("shl", 8'h17, 8'hFF, 1'b1, 3'b010, 2'b01, 2'b10, 8'h2E);
        op("shr", 8'h97, 8'hFF, 1'b1, 3'b011, 2'b01, 2'b10, 8'h4B);
        op("asr", 8'h97, 8'hFF, 1'b1, 3'b100, 2'b01, 2'b10, 8'hCB);
        op("rol", 8'h97, 8'hFF, 1'b1, 3'b101, 2'b01, 2'b10, 8'h2F);

        // Boundaries
        op("add_wrap",  8'hFF, 8'h00, 1'b1, 3'b000, 2'b00, 2'b00, 8'h00);
        op("dec_wrap",  8'h00, 8'h00, 1'b0, 3'b000, 2'b11, 2'b00, 8'hFF);
        op("pre_rsv",   8'h80, 8'h01, 1'b0, 3'b000, 2'b00, 2'b00, 8'h81);
        op("rsv110",    8'hFF, 8'hFF, 1'b1, 3'b110, 2'b00, 2'b00, 8'h00);
        op("pre_rsv7",  8'h40, 8'h02, 1'b0, 3'b001, 2'b00, 2'b01, 8'h42);
        op("rsv111",    8'hFF, 8'hFF, 1'b1, 3'b111, 2'b11, 2'b11, 8'h00);

        // Reset on the same edge as a valid add, then the add completes.
        op("pre_midreset", 8'h12, 8'h34, 1'b0, 3'b000, 2'b00, 2'b00, 8'h46);
        drive(8'h10, 8'h20, 1'b1, 3'b000, 2'b00, 2'b00, 1'b1);
        tick();
        check("midstream_reset", 8'h00);
        rst = 1'b0;
        tick();
        check("post_reset_add", 8'h31);

        // Random operations against the reference model.
        for (int i = 0; i < 400; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rc    = 1'($urandom);
            rs    = 3'($urandom);
            rcalc = 2'($urandom);
            rlg   = 2'($urandom);
            rr    = ($urandom_range(0, 15) == 0);
            exp_v = rr ? 8'h00 : model(int'(ra), int'(rb), int'(rc),
                                       int'(rs), int'(rcalc), int'(rlg));
            drive(ra, rb, rc, rs, rcalc, rlg, rr);
            tick();
            check($sformatf("rand%0d_sel%0d", i, rs), exp_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
